// File: rtl/y86_regfile_writeback.sv
// Y86-64 SEQ register file and write-back stage: 15 program registers,
// combinational operand reads, edge-committed writes and sticky status.
module y86_regfile_writeback #(
    parameter int         WIDTH = 64,
    parameter int         NREG  = 15,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       icode,
    input  logic             cnd,
    input  logic             instr_valid,
    input  logic             imemError,
    input  logic             dmemError,
    input  logic [3:0]       srcA,
    input  logic [3:0]       srcB,
    input  logic [3:0]       dstE,
    input  logic [3:0]       dstM,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valM,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    output logic [2:0]       stat,
    output logic             halted
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;
    localparam logic [3:0] ICODE_HALT = 4'h0;
    localparam logic [3:0] ICODE_CMOV = 4'h2;

    logic [WIDTH-1:0] regs_r [NREG];
    logic [2:0]       stat_r;
    logic             halted_r;
    logic [2:0]       istat_s;
    logic             commit_s;
    logic             we_e_s;
    logic             we_m_s;

    // Status of the instruction in flight; address errors outrank illegal opcodes and halt.
    function automatic logic [2:0] instr_status(
        input logic [3:0] ic,
        input logic       iv,
        input logic       imem_err,
        input logic       dmem_err
    );
        logic [2:0] s;
        if (imem_err || dmem_err) begin
            s = STAT_ADR;
        end else if (!iv) begin
            s = STAT_INS;
        end else if (ic == ICODE_HALT) begin
            s = STAT_HLT;
        end else begin
            s = STAT_AOK;
        end
        return s;
    endfunction

    // Write enables: valM owns a shared destination, and an untaken cmov drops its E write.
    always_comb begin
        istat_s  = instr_status(icode, instr_valid, imemError, dmemError);
        commit_s = (stat_r == STAT_AOK) && (istat_s == STAT_AOK) && !rst;
        we_m_s   = commit_s && (dstM != RNONE);
        we_e_s   = 1'b0;
        if (commit_s && (dstE != RNONE)) begin
            if ((icode == ICODE_CMOV) && !cnd) begin
                we_e_s = 1'b0;
            end else if (dstE == dstM) begin
                we_e_s = 1'b0;
            end else begin
                we_e_s = 1'b1;
            end
        end else begin
            we_e_s = 1'b0;
        end
    end

    // Operand reads see only committed state; RNONE reads as zero.
    always_comb begin
        valA = '0;
        valB = '0;
        if (srcA != RNONE) begin
            valA = regs_r[srcA];
        end else begin
            valA = '0;
        end
        if (srcB != RNONE) begin
            valB = regs_r[srcB];
        end else begin
            valB = '0;
        end
    end

    // Register array and sticky status; reset discards any write of the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
            stat_r   <= STAT_AOK;
            halted_r <= 1'b0;
        end else begin
            if (we_e_s) begin
                regs_r[dstE] <= valE;
            end
            if (we_m_s) begin
                regs_r[dstM] <= valM;
            end
            if (stat_r == STAT_AOK) begin
                stat_r   <= istat_s;
                halted_r <= (istat_s != STAT_AOK);
            end
        end
    end

    assign stat   = stat_r;
    assign halted = halted_r;

endmodule

// File: tb/tb_y86_regfile_writeback.sv
// Directed, table-driven bench for y86_regfile_writeback.
module tb_y86_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  icode;
    logic        cnd;
    logic        instr_valid;
    logic        imemError;
    logic        dmemError;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] valE, valM, valA, valB;
    logic [2:0]  stat;
    logic        halted;

    int tests  = 0;
    int failed = 0;

    y86_regfile_writeback dut (
        .clk(clk), .rst(rst), .icode(icode), .cnd(cnd), .instr_valid(instr_valid),
        .imemError(imemError), .dmemError(dmemError), .srcA(srcA), .srcB(srcB),
        .dstE(dstE), .dstM(dstM), .valE(valE), .valM(valM), .valA(valA), .valB(valB),
        .stat(stat), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  icode;
        logic        cnd;
        logic        iv;
        logic        imem;
        logic        dmem;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [63:0] vale;
        logic [63:0] valm;
        logic [3:0]  chka;
        logic [3:0]  chkb;
        logic [63:0] expa;
        logic [63:0] expb;
        logic [2:0]  exps;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic [3:0] ic, input logic c, input logic iv,
        input logic im, input logic dm, input logic [3:0] de, input logic [3:0] dm_,
        input logic [63:0] ve, input logic [63:0] vm, input logic [3:0] ca,
        input logic [3:0] cb, input logic [63:0] ea, input logic [63:0] eb,
        input logic [2:0] es);
        vec_t v;
        v.rst = r; v.icode = ic; v.cnd = c; v.iv = iv; v.imem = im; v.dmem = dm;
        v.dste = de; v.dstm = dm_; v.vale = ve; v.valm = vm;
        v.chka = ca; v.chkb = cb; v.expa = ea; v.expb = eb; v.exps = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Quiet, legal nop that writes nothing.
    task automatic idle();
        rst = 1'b0; icode = 4'h1; cnd = 1'b0; instr_valid = 1'b1;
        imemError = 1'b0; dmemError = 1'b0; dstE = 4'hF; dstM = 4'hF;
        valE = 64'd0; valM = 64'd0;
    endtask

    initial begin
        idle();
        srcA = 4'h0; srcB = 4'hF;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_stat", {61'd0, stat}, 64'd1);
        check("reset_halted", {63'd0, halted}, 64'd0);
        check("reset_reg0", valA, 64'd0);
        check("reset_rnone", valB, 64'd0);

        //             rst ic   c     iv    im    dm    dstE  dstM  valE          valM      chkA  chkB  expA          expB      stat
        vecs.push_back(mk(0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1, 4'h2, 64'hAA,      64'hBB,   4'h1, 4'h2, 64'hAA,       64'hBB,   3'd1));
        vecs.push_back(mk(0, 4'hB, 1'b1, 1'b1, 1'b0, 1'b0, 4'h4, 4'h4, 64'h100,     64'h200,  4'h4, 4'h1, 64'h200,      64'hAA,   3'd1));
        vecs.push_back(mk(0, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 4'hF, 64'h77,      64'h0,    4'h5, 4'h4, 64'h0,        64'h200,  3'd1));
        vecs.push_back(mk(0, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 4'hF, 64'h77,      64'h0,    4'h5, 4'h4, 64'h77,       64'h200,  3'd1));
        vecs.push_back(mk(0, 4'h6, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 64'hDEAD,    64'hBEEF, 4'hF, 4'h5, 64'h0,        64'h77,   3'd1));
        vecs.push_back(mk(0, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 4'hF, 64'h1234,    64'h0,    4'h3, 4'h2, 64'h1234,     64'hBB,   3'd1));
        vecs.push_back(mk(1, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 4'h8, 4'h9, 64'h99,      64'h98,   4'h3, 4'h8, 64'h0,        64'h0,    3'd1));
        vecs.push_back(mk(0, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 4'h6, 4'hF, 64'h11,      64'h0,    4'h6, 4'h4, 64'h11,       64'h0,    3'd1));
        vecs.push_back(mk(0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 4'h6, 64'h0,       64'h55,   4'h6, 4'hF, 64'h11,       64'h0,    3'd3));
        vecs.push_back(mk(0, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 4'h7, 4'hF, 64'h33,      64'h0,    4'h7, 4'h6, 64'h0,        64'h11,   3'd3));
        vecs.push_back(mk(1, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 64'h0,       64'h0,    4'h6, 4'h7, 64'h0,        64'h0,    3'd1));
        vecs.push_back(mk(0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h9, 4'hF, 64'h5,       64'h0,    4'h9, 4'hF, 64'h0,        64'h0,    3'd2));
        vecs.push_back(mk(0, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 4'h9, 4'hF, 64'h5,       64'h0,    4'h9, 4'hF, 64'h0,        64'h0,    3'd2));
        vecs.push_back(mk(1, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 64'h0,       64'h0,    4'h9, 4'hF, 64'h0,        64'h0,    3'd1));
        vecs.push_back(mk(0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 4'hF, 64'h6,       64'h0,    4'hA, 4'hF, 64'h0,        64'h0,    3'd4));
        vecs.push_back(mk(1, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 64'h0,       64'h0,    4'hA, 4'hF, 64'h0,        64'h0,    3'd1));
        vecs.push_back(mk(0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hB, 4'hF, 64'h7,       64'h0,    4'hB, 4'hF, 64'h0,        64'h0,    3'd3));
        vecs.push_back(mk(1, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 64'h0,       64'h0,    4'hB, 4'hF, 64'h0,        64'h0,    3'd1));
        vecs.push_back(mk(0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 4'hE, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'hE, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'd1));

        foreach (vecs[k]) begin
            @(negedge clk);
            rst = vecs[k].rst; icode = vecs[k].icode; cnd = vecs[k].cnd;
            instr_valid = vecs[k].iv; imemError = vecs[k].imem; dmemError = vecs[k].dmem;
            dstE = vecs[k].dste; dstM = vecs[k].dstm; valE = vecs[k].vale; valM = vecs[k].valm;
            @(posedge clk);
            #1;
            idle();
            srcA = vecs[k].chka; srcB = vecs[k].chkb;
            #1;
            check($sformatf("vec%0d_valA", k), valA, vecs[k].expa);
            check($sformatf("vec%0d_valB", k), valB, vecs[k].expb);
            check($sformatf("vec%0d_stat", k), {61'd0, stat}, {61'd0, vecs[k].exps});
            check($sformatf("vec%0d_halted", k), {63'd0, halted}, {63'd0, (vecs[k].exps != 3'd1)});
        end

        // Same-cycle read of a register being written shows the old value until the edge.
        @(negedge clk);
        idle();
        dstE = 4'hE; valE = 64'h1; srcA = 4'hE; srcB = 4'h0;
        #1;
        check("rdw_old", valA, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk);
        #1;
        idle();
        #1;
        check("rdw_new", valA, 64'h1);
        check("rdw_other", valB, 64'h1);

        // Sticky error spanning several cycles, released only by reset.
        @(negedge clk);
        idle(); imemError = 1'b1; dstE = 4'hC; valE = 64'h42;
        @(negedge clk);
        idle(); dstE = 4'hC; valE = 64'h43;
        @(negedge clk);
        idle(); dstM = 4'hC; valM = 64'h44;
        @(negedge clk);
        idle(); srcA = 4'hC;
        #1;
        check("sticky_stat", {61'd0, stat}, 64'd3);
        check("sticky_reg", valA, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        idle(); dstE = 4'hC; valE = 64'h45;
        @(negedge clk);
        idle();
        #1;
        check("recover_stat", {61'd0, stat}, 64'd1);
        check("recover_reg", valA, 64'h45);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
